// File: rtl/stopwatch_lap_core.sv
// stopwatch_lap_core: BCD MM:SS.hh stopwatch with prescaler,
// up/down count, preset load and a circular lap-record buffer.
module stopwatch_lap_core #(
   parameter int          TICK_DIV = 500000,
   parameter int          LAP_AW   = 3,
   parameter logic [23:0] PRESET   = 24'h010000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_start,
   input  logic              key_clear,
   input  logic              key_load,
   input  logic              key_lap,
   input  logic              key_recall,
   input  logic              mode_down,
   output logic [23:0]       disp_out,
   output logic              running,
   output logic              view_mode,
   output logic [LAP_AW:0]   lap_count,
   output logic [LAP_AW-1:0] lap_idx,
   output logic              done,
   output logic              ovf
);

   localparam int LAP_DEPTH = 2 ** LAP_AW;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      VIEW = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [PW-1:0]     presc_q;
   logic [23:0]       time_q;
   logic [23:0]       time_nx;
   logic [23:0]       disp_t;
   logic [23:0]       ram_q;
   logic              dir_q;
   logic [LAP_AW-1:0] wr_ptr;
   logic [LAP_AW-1:0] rd_addr;
   logic [23:0]       lap_ram [LAP_DEPTH];

   logic k_clr, k_start, k_load, k_lap, k_rec;
   logic tick, zero_hit, wrap_hit;
   logic clr_en, load_en, lap_en, run_en, view_en, step_en;

   // One BCD step of MM:SS.hh, rippling carry (up) or borrow (down).
   function automatic logic [23:0] bcd_step(
      input logic [23:0] t,
      input logic        down
   );
      logic [23:0] r;
      logic        c;
      logic [3:0]  d;
      logic [3:0]  mx;
      r = t;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         d  = t[4*i +: 4];
         mx = (i == 3 || i == 5) ? 4'd5 : 4'd9;
         if (c) begin
            if (down) begin
               if (d == 4'd0) begin
                  r[4*i +: 4] = mx;
                  c = 1'b1;
               end else begin
                  r[4*i +: 4] = d - 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (d == mx) begin
                  r[4*i +: 4] = 4'd0;
                  c = 1'b1;
               end else begin
                  r[4*i +: 4] = d + 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   // Fixed key priority: only the highest asserted key survives.
   assign k_clr   = key_clear;
   assign k_start = key_start & ~key_clear;
   assign k_load  = key_load & ~key_start & ~key_clear;
   assign k_lap   = key_lap & ~key_load & ~key_start & ~key_clear;
   assign k_rec   = key_recall & ~key_lap & ~key_load
                  & ~key_start & ~key_clear;

   assign tick     = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
   assign time_nx  = bcd_step(time_q, dir_q);
   assign zero_hit = tick && dir_q && (time_nx == 24'h0);
   assign wrap_hit = tick && !dir_q && (time_q == 24'h595999);

   assign rd_addr = wr_ptr - lap_count[LAP_AW-1:0] + lap_idx;

   assign running   = (state_q == RUN);
   assign view_mode = (state_q == VIEW);
   assign disp_out  = (state_q == VIEW) ? ram_q : disp_t;

   // Next state and per-state key actions.
   always_comb begin
      state_d = state_q;
      clr_en  = 1'b0;
      load_en = 1'b0;
      lap_en  = 1'b0;
      run_en  = 1'b0;
      view_en = 1'b0;
      step_en = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (k_clr) begin
               clr_en = 1'b1;
            end else if (k_start) begin
               if (!(mode_down && time_q == 24'h0)) begin
                  state_d = RUN;
                  run_en  = 1'b1;
               end
            end else if (k_load) begin
               load_en = 1'b1;
            end else if (k_rec && lap_count != '0) begin
               state_d = VIEW;
               view_en = 1'b1;
            end
         end
         RUN: begin
            if (k_start) begin
               state_d = IDLE;
            end else if (k_lap) begin
               lap_en = 1'b1;
            end
            if (zero_hit) begin
               state_d = IDLE;
            end
         end
         VIEW: begin
            if (k_start || k_clr) begin
               state_d = IDLE;
            end else if (k_rec) begin
               step_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, prescaler, time, flags and lap bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         presc_q   <= '0;
         time_q    <= '0;
         disp_t    <= '0;
         dir_q     <= 1'b0;
         ovf       <= 1'b0;
         done      <= 1'b0;
         wr_ptr    <= '0;
         lap_count <= '0;
         lap_idx   <= '0;
      end else begin
         state_q <= state_d;
         disp_t  <= time_q;
         done    <= zero_hit;
         if (clr_en || load_en) begin
            presc_q <= '0;
         end else if (state_q == RUN) begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
         end
         if (clr_en) begin
            time_q <= '0;
         end else if (load_en) begin
            time_q <= PRESET;
         end else if (tick) begin
            time_q <= time_nx;
         end
         if (clr_en || load_en) begin
            ovf <= 1'b0;
         end else if (wrap_hit) begin
            ovf <= 1'b1;
         end
         if (run_en) begin
            dir_q <= mode_down;
         end
         if (clr_en) begin
            wr_ptr    <= '0;
            lap_count <= '0;
         end else if (lap_en) begin
            wr_ptr <= wr_ptr + LAP_AW'(1);
            if (lap_count < (LAP_AW+1)'(LAP_DEPTH)) begin
               lap_count <= lap_count + (LAP_AW+1)'(1);
            end
         end
         if (view_en) begin
            lap_idx <= '0;
         end else if (step_en) begin
            if ({1'b0, lap_idx} == lap_count - (LAP_AW+1)'(1)) begin
               lap_idx <= '0;
            end else begin
               lap_idx <= lap_idx + LAP_AW'(1);
            end
         end
      end
   end

   // Lap RAM: write pre-tick time, synchronous read of the viewed entry.
   always_ff @(posedge clk) begin
      if (lap_en) begin
         lap_ram[wr_ptr] <= time_q;
      end
      ram_q <= lap_ram[rd_addr];
   end

endmodule

// File: doc/stopwatch_lap_core.md
# stopwatch_lap_core

Parametrised stopwatch core: BCD MM:SS.hh timer with on-chip tick prescaler, count-up or countdown mode, preset load, and a circular lap-record buffer that can be recalled to the display. It merges the divider, key control, counter and lap RAM into one block. It sits between debounced key pulses and the 7-segment display driver. `disp_out` feeds the display driver directly.

## Interface
- `TICK_DIV`, default 500000: clk cycles per 1/100 s tick (50 MHz → 100 Hz).
- `LAP_AW`, default 3: lap buffer address width; depth `LAP_DEPTH = 2**LAP_AW`.
- `PRESET`, default 24'h010000: value loaded by `key_load`, BCD MMSShh (01:00.00). Must be valid BCD; not checked.

- `clk` in 1: single clock (50 MHz).
- `rst` in 1: synchronous, active-high reset.
- `key_start` in 1: one-cycle pulse; run/stop toggle, also exits view.
- `key_clear` in 1: one-cycle pulse; zero time and lap buffer.
- `key_load` in 1: one-cycle pulse; load `PRESET`.
- `key_lap` in 1: one-cycle pulse; record current time.
- `key_recall` in 1: one-cycle pulse; enter view / step to next lap.
- `mode_down` in 1: count direction (1 = down); sampled only on the IDLE→RUN transition.
- `disp_out` out 24: BCD MMSShh shown on the display.
- `running` out 1: high in RUN.
- `view_mode` out 1: high in VIEW.
- `lap_count` out LAP_AW+1: number of valid laps (0..LAP_DEPTH).
- `lap_idx` out LAP_AW: lap being viewed, 0 = oldest.
- `done` out 1: one-cycle pulse when a countdown reaches zero.
- `ovf` out 1: sticky flag, up-count wrapped.

## Operation
- States: IDLE, RUN, VIEW. Reset → IDLE. All outputs reset to 0. Time, prescaler, direction, write pointer and lap count also reset to 0.
- Key priority: clear > start > load > lap > recall. Only the highest-priority asserted key is acted on in a cycle; the others are dropped.
- IDLE:
  - `key_start` → RUN and latch `mode_down` into the direction register. Ignored if the latched direction would be down and time = 0.
  - `key_clear` → time = 0, `ovf` = 0, `lap_count` = 0, write pointer = 0.
  - `key_load` → time = `PRESET`, `ovf` = 0.
  - `key_recall` with `lap_count` > 0 → VIEW, `lap_idx` = 0. Otherwise ignored.
  - `key_lap` is ignored.
- RUN:
  - `key_start` → IDLE. The prescaler is held, not cleared.
  - `key_lap` writes the current time at the write pointer, then the pointer increments modulo LAP_DEPTH. `lap_count` saturates at LAP_DEPTH; when full, the oldest entry is overwritten.
  - `key_clear`, `key_load` and `key_recall` are ignored.
- VIEW:
  - `key_recall` → `lap_idx` increments, wrapping from `lap_count`−1 to 0.
  - `key_start` or `key_clear` → IDLE. No other effect: clear is not applied, run is not started.
  - Time is frozen.
- Lap read address = (wr_ptr − lap_count + lap_idx) mod LAP_DEPTH.
- Prescaler:
  - Counts 0..TICK_DIV−1 only in RUN; tick on the cycle it equals TICK_DIV−1, then wraps to 0.
  - Cleared on reset, clear and load.
- BCD arithmetic: hh 00–99, SS 00–59, MM 00–59, each digit 0–9 with ripple carry or borrow.
  - Up count: 59:59.99 + tick → 00:00.00, sets `ovf`, keeps running.
  - Down count: a tick that reaches 00:00.00 forces IDLE and raises `done`.
- `disp_out` shows the time register in IDLE and RUN, and lap entry `lap_idx` in VIEW.

## Timing
- All state updates happen on the `clk` rising edge. Keys are sampled on the same edge.
- `disp_out` is registered: it shows new time 1 cycle after the tick edge that updated it. In VIEW it shows the new entry 1 cycle after `lap_idx` changes, so a synchronous-read RAM is allowed.
- A lap recorded in the same cycle as a tick stores the pre-tick value.
- `done` is high for exactly one cycle, on the cycle after the zero-reaching tick. `running` falls in the same cycle.
- `rst` asserted in any state: every output is 0 on the following cycle. The lap contents need not be cleared, but `lap_count` = 0 makes them invisible.

## Test plan
- TICK_DIV=4, up count: rst, `key_start`, 40 cycles, `key_start` → `disp_out` = 24'h000010, `running` = 0, value holds for a further 100 cycles.
- PRESET=24'h595998, up: load, start, 2 ticks → `disp_out` = 24'h000000, `ovf` = 1, `running` = 1. Then stop and `key_clear` → `ovf` = 0.
- PRESET=24'h000003, `mode_down` = 1: load, start → after 3 ticks `disp_out` = 24'h000000, `done` pulses 1 cycle, `running` = 0. A further `key_start` is ignored.
- LAP_AW=2: laps taken at times 000001..000005, stop, then recall 5× → `lap_count` = 4, displays 000002, 000003, 000004, 000005, 000002.
- Simultaneous events in RUN:
  - `key_lap` on a tick cycle → stored value is the pre-tick value.
  - `key_start` + `key_lap` in the same cycle → stops, `lap_count` unchanged.
  - `key_clear` + `key_start` in IDLE → cleared, stays IDLE.
- `rst` pulse in VIEW and in RUN mid-count → next cycle `disp_out`, `running`, `view_mode`, `lap_count`, `ovf` are all 0 and the state is IDLE.
